// File: rtl/video_start_ctrl.sv
// Start-up and pattern-switch sequencer for the clk_pixel video pipeline.
// Releases the timing generator after the PLL settles and blanks whole frames around every change.
module video_start_ctrl #(
  parameter int C_settle_cycles   = 1024,
  parameter int C_blank_frames    = 2,
  parameter int C_debounce_cycles = 65536,
  parameter int C_patterns        = 4,
  parameter bit C_vsync_pol       = 1'b1
) (
  input  logic       clk_pixel,
  input  logic       resetn,
  input  logic       clk_locked,
  input  logic       btn_next,
  input  logic       vga_vsync,
  output logic       vga_resetn,
  output logic       test_picture,
  output logic [1:0] pattern_sel,
  output logic       force_blank,
  output logic       running
);

  localparam int SW = (C_settle_cycles > 1) ? $clog2(C_settle_cycles) : 1;
  localparam int FW = (C_blank_frames > 1) ? $clog2(C_blank_frames) : 1;
  localparam int DW = (C_debounce_cycles > 1) ? $clog2(C_debounce_cycles) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(C_settle_cycles - 1);
  localparam logic [FW-1:0] FRAME_LAST  = FW'(C_blank_frames - 1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(C_debounce_cycles - 1);
  localparam logic [1:0]    PAT_LAST    = 2'(C_patterns - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK, SETTLE, START_BLANK, ACTIVE, SW_WAIT, SW_BLANK
  } state_t;

  state_t        state_reg;
  logic [1:0]    btn_sync_reg;
  logic          btn_db_reg;
  logic          btn_db_prev_reg;
  logic [DW-1:0] db_cnt_reg;
  logic          vs_act_reg;
  logic          vs_prev_reg;
  logic [SW-1:0] settle_cnt_reg;
  logic [FW-1:0] frame_cnt_reg;
  logic          press;
  logic          frame_tick;

  // A change on the synchronised button must persist for the full debounce window.
  always_ff @(posedge clk_pixel) begin
    if (!resetn) begin
      btn_sync_reg    <= 2'b00;
      btn_db_reg      <= 1'b0;
      btn_db_prev_reg <= 1'b0;
      db_cnt_reg      <= '0;
      vs_act_reg      <= 1'b0;
      vs_prev_reg     <= 1'b0;
    end else begin
      btn_sync_reg    <= {btn_sync_reg[0], btn_next};
      btn_db_prev_reg <= btn_db_reg;
      vs_act_reg      <= vga_vsync ~^ C_vsync_pol;
      vs_prev_reg     <= vs_act_reg;
      if (btn_sync_reg[1] == btn_db_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DEB_LAST) begin
        btn_db_reg <= btn_sync_reg[1];
        db_cnt_reg <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + DW'(1);
      end
    end
  end

  assign press      = btn_db_reg & ~btn_db_prev_reg;
  assign frame_tick = vs_act_reg & ~vs_prev_reg & vga_resetn;

  always_ff @(posedge clk_pixel) begin
    if (!resetn) begin
      state_reg      <= WAIT_LOCK;
      settle_cnt_reg <= '0;
      frame_cnt_reg  <= '0;
      vga_resetn     <= 1'b0;
      test_picture   <= 1'b0;
      pattern_sel    <= 2'd0;
      force_blank    <= 1'b1;
      running        <= 1'b0;
    end else if (!clk_locked && state_reg != WAIT_LOCK) begin
      // Lock loss restarts the whole sequence but keeps the chosen pattern.
      state_reg    <= WAIT_LOCK;
      vga_resetn   <= 1'b0;
      test_picture <= 1'b0;
      force_blank  <= 1'b1;
      running      <= 1'b0;
    end else begin
      case (state_reg)
        WAIT_LOCK: begin
          vga_resetn   <= 1'b0;
          test_picture <= 1'b0;
          force_blank  <= 1'b1;
          running      <= 1'b0;
          if (clk_locked) begin
            state_reg      <= SETTLE;
            settle_cnt_reg <= '0;
          end
        end
        SETTLE: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            state_reg     <= START_BLANK;
            vga_resetn    <= 1'b1;
            test_picture  <= 1'b1;
            frame_cnt_reg <= '0;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + SW'(1);
          end
        end
        START_BLANK, SW_BLANK: begin
          if (frame_tick) begin
            if (frame_cnt_reg == FRAME_LAST) begin
              state_reg   <= ACTIVE;
              force_blank <= 1'b0;
              running     <= 1'b1;
            end else begin
              frame_cnt_reg <= frame_cnt_reg + FW'(1);
            end
          end
        end
        ACTIVE: begin
          if (press) begin
            state_reg   <= SW_WAIT;
            force_blank <= 1'b1;
            running     <= 1'b0;
          end
        end
        SW_WAIT: begin
          if (frame_tick) begin
            pattern_sel   <= (pattern_sel == PAT_LAST) ? 2'd0 : pattern_sel + 2'd1;
            frame_cnt_reg <= '0;
            state_reg     <= SW_BLANK;
          end
        end
        default: state_reg <= WAIT_LOCK;
      endcase
    end
  end

endmodule

// File: tb/tb_video_start_ctrl.sv
// Bench for video_start_ctrl: directed start-up/switch scenarios plus random traffic,
// every cycle compared against a frame-level reference model of the sequencer.
module tb_video_start_ctrl;

  localparam int SET  = 8;
  localparam int BLK  = 2;
  localparam int DEB  = 4;
  localparam int PATS = 3;
  localparam bit POL  = 1'b1;

  localparam int P_LOCK   = 0;
  localparam int P_SETTLE = 1;
  localparam int P_BLANK  = 2;
  localparam int P_ACTIVE = 3;
  localparam int P_WAIT   = 4;

  logic       clk_pixel = 1'b0;
  logic       resetn = 1'b0;
  logic       clk_locked = 1'b0;
  logic       btn_next = 1'b0;
  logic       vga_vsync = 1'b0;
  logic       vga_resetn;
  logic       test_picture;
  logic [1:0] pattern_sel;
  logic       force_blank;
  logic       running;

  int n_vec = 0;
  int n_err = 0;
  int exp_pat = 0;

  int m_ph = P_LOCK;
  int m_cnt = 0;
  int m_pat = 0;
  int m_run = 0;
  bit m_b1, m_b2, m_v1, m_v2, m_db, m_dbp;

  always #5 clk_pixel = ~clk_pixel;

  video_start_ctrl #(
    .C_settle_cycles(SET),
    .C_blank_frames(BLK),
    .C_debounce_cycles(DEB),
    .C_patterns(PATS),
    .C_vsync_pol(POL)
  ) dut (
    .clk_pixel(clk_pixel),
    .resetn(resetn),
    .clk_locked(clk_locked),
    .btn_next(btn_next),
    .vga_vsync(vga_vsync),
    .vga_resetn(vga_resetn),
    .test_picture(test_picture),
    .pattern_sel(pattern_sel),
    .force_blank(force_blank),
    .running(running)
  );

  // Reference: button seen two edges late, accepted after DEB consecutive differing samples;
  // a frame tick is a vsync-active start seen one edge late. Both blank phases share one state.
  always @(posedge clk_pixel) begin : model_b
    bit sync_v, tick_v, press_v;
    if (!resetn) begin
      m_b1 = 0; m_b2 = 0; m_v1 = 0; m_v2 = 0; m_db = 0; m_dbp = 0;
      m_run = 0; m_ph = P_LOCK; m_cnt = 0; m_pat = 0;
    end else begin
      sync_v = m_b2;
      m_b2 = m_b1;
      m_b1 = btn_next;
      tick_v = m_v1 && !m_v2;
      m_v2 = m_v1;
      m_v1 = (vga_vsync == POL);
      press_v = m_db && !m_dbp;
      m_dbp = m_db;
      if (sync_v != m_db) begin
        m_run++;
        if (m_run == DEB) begin
          m_db = sync_v;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      if (!clk_locked && m_ph != P_LOCK) begin
        m_ph = P_LOCK;
      end else begin
        case (m_ph)
          P_LOCK:   if (clk_locked) begin m_ph = P_SETTLE; m_cnt = 0; end
          P_SETTLE: begin
            m_cnt++;
            if (m_cnt == SET) begin m_ph = P_BLANK; m_cnt = 0; end
          end
          P_BLANK:  if (tick_v) begin
            m_cnt++;
            if (m_cnt == BLK) m_ph = P_ACTIVE;
          end
          P_ACTIVE: if (press_v) m_ph = P_WAIT;
          P_WAIT:   if (tick_v) begin m_pat = (m_pat + 1) % PATS; m_cnt = 0; m_ph = P_BLANK; end
          default:  m_ph = P_LOCK;
        endcase
      end
    end
  end

  // Free-running vsync with a randomised frame length and a 3-cycle active pulse.
  initial begin : vsync_gen
    int per;
    forever begin
      per = $urandom_range(18, 28);
      for (int i = 0; i < per; i++) begin
        @(negedge clk_pixel);
        vga_vsync = (i < 3) ? POL : ~POL;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk_pixel);
    check_val("vga_resetn", 32'(vga_resetn), 32'(m_ph >= P_BLANK));
    check_val("test_picture", 32'(test_picture), 32'(m_ph >= P_BLANK));
    check_val("force_blank", 32'(force_blank), 32'(m_ph != P_ACTIVE));
    check_val("running", 32'(running), 32'(m_ph == P_ACTIVE));
    check_val("pattern_sel", 32'(pattern_sel), 32'(m_pat));
  endtask

  task automatic measure_release(input string tag);
    int n = 0;
    while (!vga_resetn && n < 100) begin
      step();
      if (!vga_resetn) n++;
    end
    check_val(tag, n, SET);
  endtask

  task automatic wait_active(input string tag);
    int n = 0;
    while (!running && n < 400) begin
      step();
      n++;
    end
    check_val(tag, 32'(running), 1);
  endtask

  task automatic press_btn(input bit bouncy);
    if (bouncy) begin
      repeat (4) begin
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        repeat ($urandom_range(1, 3)) step();
      end
    end
    btn_next = 1'b1;
    repeat (20) step();
    btn_next = 1'b0;
    repeat (8) step();
    wait_active(bouncy ? "bouncy_back_active" : "clean_back_active");
    exp_pat = (exp_pat + 1) % PATS;
    check_val(bouncy ? "bouncy_pattern" : "clean_pattern", 32'(pattern_sel), exp_pat);
    $display("press bouncy=%0d pattern_sel=%0d", bouncy, pattern_sel);
  endtask

  initial begin : stim
    int n;
    // 1: reset with lock already high, then start-up
    resetn = 1'b0;
    clk_locked = 1'b1;
    repeat (5) step();
    check_val("rst_vga_resetn", 32'(vga_resetn), 0);
    check_val("rst_force_blank", 32'(force_blank), 1);
    check_val("rst_running", 32'(running), 0);
    check_val("rst_pattern", 32'(pattern_sel), 0);
    resetn = 1'b1;
    measure_release("startup_release_cycles");
    wait_active("startup_active");
    $display("startup done pattern_sel=%0d", pattern_sel);

    // 2: short lock pulse restarts the settle count
    clk_locked = 1'b0;
    repeat (3) step();
    clk_locked = 1'b1;
    repeat (5) step();
    clk_locked = 1'b0;
    repeat (2) step();
    clk_locked = 1'b1;
    measure_release("relock_release_cycles");
    wait_active("relock_active");
    $display("relock done pattern_sel=%0d", pattern_sel);

    // 3: three clean presses walk the pattern through its wrap
    for (int i = 0; i < 3; i++) press_btn(1'b0);
    // 4: bouncing button gives one press
    press_btn(1'b1);

    // 5: lock drop during the switch blanking
    btn_next = 1'b1;
    n = 0;
    while (pattern_sel == 2'(exp_pat) && n < 200) begin
      step();
      n++;
    end
    exp_pat = (exp_pat + 1) % PATS;
    check_val("swblank_pattern", 32'(pattern_sel), exp_pat);
    btn_next = 1'b0;
    clk_locked = 1'b0;
    step();
    check_val("drop_vga_resetn", 32'(vga_resetn), 0);
    check_val("drop_force_blank", 32'(force_blank), 1);
    check_val("drop_running", 32'(running), 0);
    check_val("drop_pattern_held", 32'(pattern_sel), exp_pat);
    repeat (3) step();
    clk_locked = 1'b1;
    measure_release("drop_release_cycles");
    wait_active("drop_active");
    check_val("drop_pattern_after", 32'(pattern_sel), exp_pat);
    $display("lock drop recovered pattern_sel=%0d", pattern_sel);

    // 6: a press during start-up blanking is dropped
    resetn = 1'b0;
    repeat (3) step();
    exp_pat = 0;
    check_val("rst2_pattern", 32'(pattern_sel), 0);
    resetn = 1'b1;
    measure_release("rst2_release_cycles");
    btn_next = 1'b1;
    repeat (10) step();
    btn_next = 1'b0;
    wait_active("rst2_active");
    repeat (30) step();
    check_val("startblank_press_dropped", 32'(pattern_sel), 0);
    check_val("startblank_still_active", 32'(running), 1);
    $display("start-blank press dropped pattern_sel=%0d", pattern_sel);

    // random traffic on button and lock
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) btn_next = ~btn_next;
      if (clk_locked && $urandom_range(0, 499) == 0) clk_locked = 1'b0;
      else if (!clk_locked && $urandom_range(0, 3) == 0) clk_locked = 1'b1;
      step();
    end
    $display("random traffic done pattern_sel=%0d", pattern_sel);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
